regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 64, data width of each register.
REQ-002 Parameter NREG, default 32, register count; SHALL be a power of two, at least 2.
REQ-003 Parameter AW, default $clog2(NREG), register address width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 rs1, rs2  input  AW each  read addresses.
REQ-007 data1, data2  output  XLEN each  read data.
REQ-008 busy1, busy2  output  1 each  scoreboard busy state of rs1 and rs2.
REQ-009 we_reg  input  1  writeback enable.
REQ-010 rd  input  AW  writeback address.
REQ-011 dataW  input  XLEN  writeback data.
REQ-012 issue  input  1  marks a destination register as pending.
REQ-013 issue_rd  input  AW  destination being issued.
REQ-014 flush  input  1  clears all pending marks.
REQ-015 busy_cnt  output  AW+1  number of registers currently pending.

Function
REQ-016 Register 0 SHALL read as zero, ignore writes and never be marked busy.
REQ-017 Read ports SHALL be combinational, with zero-cycle latency.
REQ-018 On a rising edge with we_reg=1 and rd!=0, reg[rd] SHALL take dataW.
REQ-019 Write-through bypass: when we_reg=1, rd!=0 and rsN==rd in the same cycle, dataN SHALL equal dataW, not the stored value.
REQ-020 On a rising edge with issue=1 and issue_rd!=0, busy[issue_rd] SHALL be set.
REQ-021 On a rising edge with we_reg=1 and rd!=0, busy[rd] SHALL be cleared.
REQ-022 If issue and writeback target the same register in one cycle, set SHALL win and busy stays 1.
REQ-023 Combinational busy view: busyN = busy[rsN], forced to 0 when we_reg=1 and rd==rsN, and forced to 1 when issue=1 and issue_rd==rsN; the issue term has priority, and rsN==0 always gives 0.
REQ-024 Writeback to a non-busy register SHALL still update data and SHALL leave busy_cnt unchanged.
REQ-025 Issue to an already-busy register SHALL leave busy_cnt unchanged; no double count.
REQ-026 busy_cnt SHALL be the registered population count of busy[], updated on the same edge as busy[], with a range of 0..NREG-1 and no wrap.
REQ-027 flush=1 on a rising edge SHALL clear every busy bit and set busy_cnt to 0.
REQ-028 flush SHALL take priority over an issue in the same cycle; a same-cycle data write SHALL still complete.
REQ-029 flush SHALL NOT alter register contents.

Reset
REQ-030 When rst=0 on a rising edge, all NREG registers SHALL become 0, all busy bits SHALL become 0 and busy_cnt SHALL become 0.
REQ-031 Reset SHALL override we_reg, issue and flush in the same cycle.
REQ-032 Reset asserted mid-operation SHALL discard all pending marks without any partial state.
REQ-033 While rst=0, read outputs SHALL follow the combinational rules above.
REQ-034 After the first reset edge, data1, data2, busy1 and busy2 SHALL be 0 until a write or issue occurs.

Verification
REQ-035 Reset, then write reg[5]=0xDEAD_BEEF_0000_0001; next cycle with rs1=5 -> data1=0xDEADBEEF00000001.
REQ-036 we_reg=1, rd=7, dataW=0x1234 and rs2=7 in the same cycle -> data2=0x1234 before the edge.
REQ-037 Write rd=0 with 0xFFFF; issue issue_rd=0 -> data1 with rs1=0 is 0, busy1=0, busy_cnt=0.
REQ-038 Issue regs 3, 4 and 9 in three cycles -> busy_cnt=3.
    Then writeback rd=4 together with issue_rd=4 -> busy_cnt=3 and busy[4]=1.
    Then writeback rd=3 -> busy_cnt=2.
REQ-039 With regs 1, 2 and 3 busy, assert flush and issue_rd=6 in the same cycle -> busy_cnt=0 and busy[6]=0; register contents are unchanged.
REQ-040 With NREG-1 registers busy (busy_cnt=31 at default), pulse rst=0 -> busy_cnt=0, all data reads 0, no wrap observed.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register file bundle: two read ports, one writeback port,
// plus issue/flush scoreboard control and the pending count.
interface regfile_sb_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) ();
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            busy1;
    logic            busy2;
    logic            we_reg;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dataW;
    logic            issue;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1,
        output rs2,
        output we_reg,
        output rd,
        output dataW,
        output issue,
        output issue_rd,
        output flush,
        input  data1,
        input  data2,
        input  busy1,
        input  busy2,
        input  busy_cnt
    );

    modport slave (
        input  rs1,
        input  rs2,
        input  we_reg,
        input  rd,
        input  dataW,
        input  issue,
        input  issue_rd,
        input  flush,
        output data1,
        output data2,
        output busy1,
        output busy2,
        output busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass and a per-register
// pending scoreboard; x0 is hardwired to zero and never pending.
module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_n;
    logic [AW:0]     busy_cnt;
    logic [AW:0]     cnt_n;
    logic            wr_en;
    logic            set_en;

    assign wr_en  = bus.we_reg && (bus.rd != '0);
    assign set_en = bus.issue && (bus.issue_rd != '0);

    always_comb begin
        bus.data1 = regs[bus.rs1];
        if (bus.rs1 == '0) begin
            bus.data1 = '0;
        end else if (wr_en && (bus.rd == bus.rs1)) begin
            bus.data1 = bus.dataW;
        end
    end

    always_comb begin
        bus.data2 = regs[bus.rs2];
        if (bus.rs2 == '0) begin
            bus.data2 = '0;
        end else if (wr_en && (bus.rd == bus.rs2)) begin
            bus.data2 = bus.dataW;
        end
    end

    // An in-flight issue outranks a same-cycle writeback in the view.
    always_comb begin
        bus.busy1 = busy[bus.rs1];
        if (bus.rs1 == '0) begin
            bus.busy1 = 1'b0;
        end else if (bus.issue && (bus.issue_rd == bus.rs1)) begin
            bus.busy1 = 1'b1;
        end else if (bus.we_reg && (bus.rd == bus.rs1)) begin
            bus.busy1 = 1'b0;
        end
    end

    always_comb begin
        bus.busy2 = busy[bus.rs2];
        if (bus.rs2 == '0) begin
            bus.busy2 = 1'b0;
        end else if (bus.issue && (bus.issue_rd == bus.rs2)) begin
            bus.busy2 = 1'b1;
        end else if (bus.we_reg && (bus.rd == bus.rs2)) begin
            bus.busy2 = 1'b0;
        end
    end

    // Clear before set so a same-register issue keeps the mark.
    always_comb begin
        busy_n = busy;
        if (bus.flush) begin
            busy_n = '0;
        end else begin
            if (wr_en) begin
                busy_n[bus.rd] = 1'b0;
            end
            if (set_en) begin
                busy_n[bus.issue_rd] = 1'b1;
            end
        end
        busy_n[0] = 1'b0;
    end

    always_comb begin
        cnt_n = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_n = cnt_n + (AW+1)'(busy_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy     <= busy_n;
            busy_cnt <= cnt_n;
            if (wr_en) begin
                regs[bus.rd] <= bus.dataW;
            end
        end
    end

    assign bus.busy_cnt = busy_cnt;

    a_x0_idle: assert property (
        @(posedge clk) disable iff (!rst) busy[0] == 1'b0
    );

    a_cnt_pop: assert property (
        @(posedge clk) disable iff (!rst)
        busy_cnt == (AW+1)'($countones(busy))
    );

    a_cnt_max: assert property (
        @(posedge clk) disable iff (!rst)
        busy_cnt <= (AW+1)'(NREG - 1)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_sb;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    logic [XLEN-1:0] mreg [NREG];
    logic [NREG-1:0] mbusy;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference architectural state, advanced from the pin values at each edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mreg[i] = '0;
            mbusy = '0;
        end else begin
            if (bus.we_reg && bus.rd != 0) mreg[bus.rd] = bus.dataW;
            if (bus.flush) begin
                mbusy = '0;
            end else begin
                if (bus.we_reg && bus.rd != 0) mbusy[bus.rd] = 1'b0;
                if (bus.issue && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        if (bus.we_reg && bus.rd == rs) return bus.dataW;
        return mreg[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        if (bus.issue && bus.issue_rd == rs) return 1'b1;
        if (bus.we_reg && bus.rd == rs) return 1'b0;
        return mbusy[rs];
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("m_data1", bus.data1, exp_data(bus.rs1));
            chk("m_data2", bus.data2, exp_data(bus.rs2));
            chk("m_busy1", 64'(bus.busy1), 64'(exp_busy(bus.rs1)));
            chk("m_busy2", 64'(bus.busy2), 64'(exp_busy(bus.rs2)));
            chk("m_cnt", 64'(bus.busy_cnt), 64'($countones(mbusy)));
        end
    end

    task automatic idle();
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.we_reg   = 1'b0;
        bus.rd       = '0;
        bus.dataW    = '0;
        bus.issue    = 1'b0;
        bus.issue_rd = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        checking = 1'b1;

        bus.rs1 = 5'd5;
        bus.rs2 = 5'd9;
        @(negedge clk);
        chk("rst_data1", bus.data1, 64'h0);
        chk("rst_busy1", 64'(bus.busy1), 64'h0);
        chk("rst_cnt", 64'(bus.busy_cnt), 64'h0);
        step();

        bus.we_reg = 1'b1;
        bus.rd     = 5'd5;
        bus.dataW  = 64'hDEAD_BEEF_0000_0001;
        step();
        idle();
        bus.rs1 = 5'd5;
        @(negedge clk);
        chk("wr5_data1", bus.data1, 64'hDEAD_BEEF_0000_0001);
        step();

        bus.we_reg = 1'b1;
        bus.rd     = 5'd7;
        bus.dataW  = 64'h1234;
        bus.rs2    = 5'd7;
        @(negedge clk);
        chk("byp_data2", bus.data2, 64'h1234);
        step();

        idle();
        bus.we_reg   = 1'b1;
        bus.rd       = 5'd0;
        bus.dataW    = 64'hFFFF;
        bus.issue    = 1'b1;
        bus.issue_rd = 5'd0;
        @(negedge clk);
        chk("x0_byp", bus.data1, 64'h0);
        chk("x0_busy", 64'(bus.busy1), 64'h0);
        step();
        idle();
        @(negedge clk);
        chk("x0_data", bus.data1, 64'h0);
        chk("x0_cnt", 64'(bus.busy_cnt), 64'h0);
        step();

        bus.issue = 1'b1;
        bus.issue_rd = 5'd3;
        step();
        bus.issue_rd = 5'd4;
        step();
        bus.issue_rd = 5'd9;
        step();
        idle();
        @(negedge clk);
        chk("iss3_cnt", 64'(bus.busy_cnt), 64'd3);
        bus.we_reg   = 1'b1;
        bus.rd       = 5'd4;
        bus.dataW    = 64'h44;
        bus.issue    = 1'b1;
        bus.issue_rd = 5'd4;
        step();
        idle();
        bus.rs1 = 5'd4;
        @(negedge clk);
        chk("same_cnt", 64'(bus.busy_cnt), 64'd3);
        chk("same_busy4", 64'(bus.busy1), 64'h1);
        bus.we_reg = 1'b1;
        bus.rd     = 5'd3;
        bus.dataW  = 64'h33;
        step();
        idle();
        @(negedge clk);
        chk("wb3_cnt", 64'(bus.busy_cnt), 64'd2);

        bus.flush = 1'b1;
        step();
        idle();
        bus.issue = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            bus.issue_rd = AW'(r);
            step();
        end
        idle();
        @(negedge clk);
        chk("iss123_cnt", 64'(bus.busy_cnt), 64'd3);
        bus.flush    = 1'b1;
        bus.issue    = 1'b1;
        bus.issue_rd = 5'd6;
        bus.we_reg   = 1'b1;
        bus.rd       = 5'd2;
        bus.dataW    = 64'h222;
        step();
        idle();
        bus.rs1 = 5'd6;
        bus.rs2 = 5'd5;
        @(negedge clk);
        chk("fl_cnt", 64'(bus.busy_cnt), 64'h0);
        chk("fl_busy6", 64'(bus.busy1), 64'h0);
        chk("fl_keep5", bus.data2, 64'hDEAD_BEEF_0000_0001);
        step();
        bus.rs1 = 5'd2;
        bus.rs2 = 5'd7;
        @(negedge clk);
        chk("fl_wr2", bus.data1, 64'h222);
        chk("fl_keep7", bus.data2, 64'h1234);
        step();

        idle();
        bus.issue = 1'b1;
        for (int r = 1; r < NREG; r++) begin
            bus.issue_rd = AW'(r);
            step();
        end
        idle();
        bus.rs1 = 5'd31;
        @(negedge clk);
        chk("full_cnt", 64'(bus.busy_cnt), 64'd31);
        chk("full_busy31", 64'(bus.busy1), 64'h1);
        rst          = 1'b0;
        bus.we_reg   = 1'b1;
        bus.rd       = 5'd8;
        bus.dataW    = 64'h8888;
        bus.issue    = 1'b1;
        bus.issue_rd = 5'd8;
        step();
        rst = 1'b1;
        idle();
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd8;
        @(negedge clk);
        chk("rst2_cnt", 64'(bus.busy_cnt), 64'h0);
        chk("rst2_data5", bus.data1, 64'h0);
        chk("rst2_data8", bus.data2, 64'h0);
        chk("rst2_busy8", 64'(bus.busy2), 64'h0);
        step();

        for (int k = 0; k < 400; k++) begin
            bus.rs1      = AW'($urandom);
            bus.rs2      = ($urandom % 4 == 0) ? bus.rd : AW'($urandom);
            bus.we_reg   = 1'($urandom);
            bus.rd       = AW'($urandom);
            bus.dataW    = {$urandom, $urandom};
            bus.issue    = ($urandom % 3) != 0;
            bus.issue_rd = ($urandom % 5 == 0) ? bus.rd : AW'($urandom);
            bus.flush    = ($urandom % 20) == 0;
            rst          = ($urandom % 80) != 0;
            step();
        end
        rst = 1'b1;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
